// File: rtl/image_stream_feeder_if.sv
// Handshake bundle between the pixel loader, the image_stream_feeder and the CNN input.
// The slave modport is the feeder's view; master is the view of whatever drives it.
interface image_stream_feeder_if #(
  parameter int DATA_W = 32
);
  logic                     wr_en;
  logic signed [DATA_W-1:0] wr_data;
  logic                     launch;
  logic                     din_ready;
  logic                     conv1_done;
  logic                     start;
  logic signed [DATA_W-1:0] dout;
  logic                     buf_full;
  logic                     frame_done;
  logic                     err;

  modport master (
    output wr_en, wr_data, launch, din_ready, conv1_done,
    input  start, dout, buf_full, frame_done, err
  );

  modport slave (
    input  wr_en, wr_data, launch, din_ready, conv1_done,
    output start, dout, buf_full, frame_done, err
  );
endinterface

// File: rtl/image_stream_feeder.sv
// Buffers one NPIX-word image, then streams it word-by-word to the CNN on request
// and waits for the first-layer completion before accepting the next image.
module image_stream_feeder #(
  parameter int DATA_W = 32,
  parameter int NPIX   = 784
) (
  input  logic                 clk,
  input  logic                 rstn,
  image_stream_feeder_if.slave bus
);
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    READY     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [CNT_W-1:0]         wr_cnt_r;
  logic [CNT_W-1:0]         rd_cnt_r;
  logic signed [DATA_W-1:0] mem_r [NPIX];
  logic signed [DATA_W-1:0] dout_r;
  logic                     start_r;
  logic                     buf_full_r;
  logic                     frame_done_r;
  logic                     err_r;

  logic wr_do_s;
  logic rd_do_s;
  logic wr_clr_s;
  logic rd_clr_s;
  logic stray_wr_s;
  logic early_done_s;
  logic done_s;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_next_s = state_r;
    wr_do_s      = 1'b0;
    rd_do_s      = 1'b0;
    wr_clr_s     = 1'b0;
    rd_clr_s     = 1'b0;
    early_done_s = 1'b0;
    done_s       = 1'b0;
    stray_wr_s   = bus.wr_en && (state_r != LOAD);
    case (state_r)
      LOAD: begin
        if (bus.wr_en) begin
          wr_do_s = 1'b1;
          if (wr_cnt_r == LAST_IDX) begin
            state_next_s = READY;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s = LOAD;
        end
      end
      READY: begin
        if (bus.launch) begin
          rd_clr_s     = 1'b1;
          state_next_s = STREAM;
        end else begin
          state_next_s = READY;
        end
      end
      STREAM: begin
        rd_do_s = bus.din_ready;
        // An early completion aborts the frame; it takes priority over the last request.
        if (bus.conv1_done) begin
          early_done_s = 1'b1;
          wr_clr_s     = 1'b1;
          state_next_s = LOAD;
        end else if (bus.din_ready && (rd_cnt_r == LAST_IDX)) begin
          state_next_s = WAIT_DONE;
        end else begin
          state_next_s = STREAM;
        end
      end
      WAIT_DONE: begin
        if (bus.conv1_done) begin
          done_s       = 1'b1;
          wr_clr_s     = 1'b1;
          state_next_s = LOAD;
        end else begin
          state_next_s = WAIT_DONE;
        end
      end
      default: begin
        state_next_s = LOAD;
      end
    endcase
  end

  // Write and read pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_r <= {CNT_W{1'b0}};
      rd_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (wr_clr_s) begin
        wr_cnt_r <= {CNT_W{1'b0}};
      end else if (wr_do_s) begin
        wr_cnt_r <= wr_cnt_r + CNT_W'(1);
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end
      if (rd_clr_s) begin
        rd_cnt_r <= {CNT_W{1'b0}};
      end else if (rd_do_s) begin
        rd_cnt_r <= rd_cnt_r + CNT_W'(1);
      end else begin
        rd_cnt_r <= rd_cnt_r;
      end
    end
  end

  // Image buffer; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (wr_do_s) begin
      mem_r[wr_cnt_r[AW-1:0]] <= bus.wr_data;
    end
  end

  // Pixel presented to the CNN; holds between requests and after the last one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_r <= {DATA_W{1'b0}};
    end else if (rd_do_s) begin
      dout_r <= mem_r[rd_cnt_r[AW-1:0]];
    end else begin
      dout_r <= dout_r;
    end
  end

  // Status outputs are decoded from the next state so they change with the state itself
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_r      <= 1'b0;
      buf_full_r   <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      start_r      <= (state_next_s == STREAM) || (state_next_s == WAIT_DONE);
      buf_full_r   <= (state_next_s != LOAD);
      frame_done_r <= done_s;
      err_r        <= err_r | stray_wr_s | early_done_s;
    end
  end

  assign bus.start      = start_r;
  assign bus.dout       = dout_r;
  assign bus.buf_full   = buf_full_r;
  assign bus.frame_done = frame_done_r;
  assign bus.err        = err_r;
endmodule

// File: doc/image_stream_feeder.md
IMAGE_STREAM_FEEDER -- requirements
Module: image_stream_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, pixel word width (signed).
REQ-002 SHALL have parameter NPIX, default 784, words per image (28x28).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  load strobe; one pixel is accepted per cycle while asserted.
REQ-006 SHALL have port wr_data  input  DATA_W  pixel to store, in raster order.
REQ-007 SHALL have port launch  input  1  one-cycle request to stream the buffered image.
REQ-008 SHALL have port din_ready  input  1  CNN pixel request; one word is consumed per cycle while asserted.
REQ-009 SHALL have port conv1_done  input  1  CNN first-layer completion.
REQ-010 SHALL have port start  output  1  CNN run enable.
REQ-011 SHALL have port dout  output  DATA_W  pixel presented to CNN din (registered).
REQ-012 SHALL have port buf_full  output  1  all NPIX pixels are loaded.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on image completion.
REQ-014 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL use four states: LOAD, READY, STREAM, WAIT_DONE.
REQ-016 SHALL store NPIX words in an internal buffer, using a write counter wr_cnt and a read counter rd_cnt, each ceil(log2(NPIX+1)) bits.
REQ-017 LOAD: wr_en writes wr_data to buf[wr_cnt] and increments wr_cnt; the write with wr_cnt==NPIX-1 moves the FSM to READY next cycle.
REQ-018 READY: buf_full=1; launch=1 moves the FSM to STREAM with rd_cnt=0; other inputs leave the state unchanged.
REQ-019 STREAM: start=1; each cycle with din_ready=1 loads dout with buf[rd_cnt] (new value visible the cycle after the request) and increments rd_cnt.
REQ-020 STREAM: the request with rd_cnt==NPIX-1 moves the FSM to WAIT_DONE; cycles with din_ready=0 hold dout and rd_cnt.
REQ-021 WAIT_DONE: start=1; din_ready is ignored and dout holds the last pixel.
REQ-022 WAIT_DONE: conv1_done=1 drives start=0 and frame_done=1 in the next cycle, clears wr_cnt, and returns the FSM to LOAD.
REQ-023 start SHALL be 1 only in STREAM and WAIT_DONE; it is registered and glitch-free.
REQ-024 wr_en outside LOAD SHALL be ignored (buffer unchanged) and SHALL set err.
REQ-025 launch outside READY SHALL be ignored without error.
REQ-026 conv1_done in STREAM (early) SHALL set err, drop start next cycle, and return the FSM to LOAD with wr_cnt=0.
REQ-027 conv1_done in LOAD or READY SHALL be ignored.
REQ-028 err SHALL stay set until reset.
REQ-029 buf_full SHALL be 1 in READY, STREAM and WAIT_DONE, and 0 in LOAD.
REQ-030 din_ready and wr_en asserted in the same cycle SHALL each follow its own state rule, with no interaction.

Reset
REQ-031 rstn=0 SHALL immediately set state=LOAD, wr_cnt=0, rd_cnt=0, start=0, dout=0, buf_full=0, frame_done=0, err=0; buffer contents are don't-care.
REQ-032 Reset asserted mid-STREAM SHALL abort the frame; after release, the block requires a full reload before launch is honoured.

Verification
REQ-033 Load 784 words 0..783 on consecutive cycles, then launch, then hold din_ready high -> dout=0,1,...,783 on consecutive cycles starting one cycle after the first request; FSM reaches WAIT_DONE with start=1.
REQ-034 In WAIT_DONE, pulse conv1_done -> next cycle start=0 and frame_done=1 for exactly one cycle; buf_full=0; FSM in LOAD.
REQ-035 Stream with din_ready toggling 1,0,1,0 -> dout advances only on request cycles; 784 requests total are needed to reach WAIT_DONE.
REQ-036 wr_en during STREAM, and conv1_done after 100 pixels streamed -> err=1; buffer unchanged by the stray write; FSM returns to LOAD; err persists until rstn=0.
REQ-037 launch after only 500 words are loaded -> ignored, start stays 0; after words 501..784 are loaded, launch is accepted.
REQ-038 Drive rstn low at pixel 300 of a stream -> all outputs are 0 during reset; after release, launch is ignored until 784 new words are loaded.
